// File: rtl/hv_am_search.sv
// Associative-memory search: streams class hypervectors from a 1-cycle-latency memory,
// computes the Hamming distance to the latched query and reports the closest class.
module hv_am_search #(
    parameter int HVDimension    = 512,
    parameter int NumClasses     = 16,
    parameter int ClassAddrWidth = $clog2(NumClasses),
    parameter int DistWidth      = $clog2(HVDimension + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [HVDimension-1:0]    qhv_i,
    input  logic                      qhv_valid_i,
    output logic                      qhv_ready_o,
    input  logic [ClassAddrWidth:0]   num_class_i,
    output logic                      am_rd_en_o,
    output logic [ClassAddrWidth-1:0] am_rd_addr_o,
    input  logic [HVDimension-1:0]    am_rd_data_i,
    output logic [ClassAddrWidth-1:0] predict_o,
    output logic [DistWidth-1:0]      dist_o,
    output logic                      predict_valid_o,
    input  logic                      predict_ready_i
);

    typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [HVDimension-1:0]    query_p0;
    logic [ClassAddrWidth-1:0] addr_q;
    logic [ClassAddrWidth-1:0] n_last_q;
    logic                      rd_vld_p1;
    logic [ClassAddrWidth-1:0] rd_idx_p1;
    logic [DistWidth-1:0]      dist_p1;
    logic [DistWidth-1:0]      best_dist_q;
    logic [ClassAddrWidth-1:0] best_idx_q;
    logic                      accept;
    logic                      searching;

    function automatic logic [DistWidth-1:0] popcount(input logic [HVDimension-1:0] v);
        logic [DistWidth-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < HVDimension; i++) begin
            cnt = cnt + DistWidth'(v[i]);
        end
        return cnt;
    endfunction

    // Out-of-range class counts (0 or above capacity) fall back to searching the whole memory.
    function automatic logic [ClassAddrWidth-1:0] last_index(input logic [ClassAddrWidth:0] n);
        if (n == '0 || n > (ClassAddrWidth + 1)'(NumClasses)) begin
            return ClassAddrWidth'(NumClasses - 1);
        end
        return ClassAddrWidth'(n - 1'b1);
    endfunction

    assign accept    = (state_q == IDLE) && qhv_valid_i;
    assign searching = (state_q == SEARCH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (qhv_valid_i) state_d = SEARCH;
            SEARCH:  if (addr_q == n_last_q) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (predict_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: query capture (data only, no reset needed)
    always_ff @(posedge clk_i) begin
        if (accept) begin
            query_p0 <= qhv_i;
        end
    end

    // Stage p1: read data returns alongside the delayed valid/index; compare here
    assign dist_p1 = popcount(query_p0 ^ am_rd_data_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            n_last_q    <= '0;
            rd_vld_p1   <= 1'b0;
            rd_idx_p1   <= '0;
            best_dist_q <= '0;
            best_idx_q  <= '0;
        end else begin
            rd_vld_p1 <= searching;
            rd_idx_p1 <= addr_q;
            if (accept) begin
                n_last_q    <= last_index(num_class_i);
                addr_q      <= '0;
                best_dist_q <= '1;
                best_idx_q  <= '0;
            end else begin
                if (searching) begin
                    addr_q <= addr_q + 1'b1;
                end
                // Strict less-than so ties keep the earlier (lower) class index
                if (rd_vld_p1 && (dist_p1 < best_dist_q)) begin
                    best_dist_q <= dist_p1;
                    best_idx_q  <= rd_idx_p1;
                end
            end
        end
    end

    assign qhv_ready_o     = (state_q == IDLE) && !rst_i;
    assign am_rd_en_o      = searching && !rst_i;
    assign am_rd_addr_o    = am_rd_en_o ? addr_q : '0;
    assign predict_valid_o = (state_q == DONE) && !rst_i;
    assign predict_o       = rst_i ? '0 : best_idx_q;
    assign dist_o          = rst_i ? '0 : best_dist_q;

endmodule

// File: tb/tb_hv_am_search.sv
// Directed bench for hv_am_search with a 1-cycle-latency class memory model.
module tb_hv_am_search;

    localparam int D  = 512;
    localparam int NC = 16;
    localparam int AW = 4;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [D-1:0]  qhv_i;
    logic          qhv_valid_i;
    logic          qhv_ready_o;
    logic [AW:0]   num_class_i;
    logic          am_rd_en_o;
    logic [AW-1:0] am_rd_addr_o;
    logic [D-1:0]  am_rd_data_i;
    logic [AW-1:0] predict_o;
    logic [DW-1:0] dist_o;
    logic          predict_valid_o;
    logic          predict_ready_i;

    logic [D-1:0]  mem [NC];
    int            n_checks = 0;
    int            n_fail   = 0;

    hv_am_search dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .qhv_i           (qhv_i),
        .qhv_valid_i     (qhv_valid_i),
        .qhv_ready_o     (qhv_ready_o),
        .num_class_i     (num_class_i),
        .am_rd_en_o      (am_rd_en_o),
        .am_rd_addr_o    (am_rd_addr_o),
        .am_rd_data_i    (am_rd_data_i),
        .predict_o       (predict_o),
        .dist_o          (dist_o),
        .predict_valid_o (predict_valid_o),
        .predict_ready_i (predict_ready_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (am_rd_en_o) am_rd_data_i <= mem[am_rd_addr_o];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [D-1:0] rand_hv();
        logic [D-1:0] v;
        for (int w = 0; w < D / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [D-1:0] mask_range(input int lo, input int cnt);
        logic [D-1:0] m;
        m = '0;
        for (int i = lo; i < lo + cnt; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Issues one query from IDLE and waits for the result; returns edges after the accept edge.
    task automatic run_query(input logic [D-1:0] q, input logic [AW:0] num,
                             output int lat, output int nreads, output int addr_err,
                             output logic [AW-1:0] pidx, output logic [DW-1:0] pdist);
        qhv_i       = q;
        num_class_i = num;
        qhv_valid_i = 1'b1;
        step();
        qhv_valid_i = 1'b0;
        qhv_i       = rand_hv();
        num_class_i = 5'd2;
        lat = 0; nreads = 0; addr_err = 0;
        while (!predict_valid_o && lat < 200) begin
            if (am_rd_en_o) begin
                if (am_rd_addr_o != nreads[AW-1:0]) addr_err++;
                nreads++;
            end
            step();
            lat++;
        end
        pidx  = predict_o;
        pdist = dist_o;
    endtask

    task automatic test_reset();
        int pv_seen;
        int en_seen;
        rst_i = 1'b1;
        step();
        step();
        n_checks++;
        if ({qhv_ready_o, am_rd_en_o, predict_valid_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000", {qhv_ready_o, am_rd_en_o, predict_valid_o});
        end
        n_checks++;
        if ({am_rd_addr_o, predict_o, dist_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%0d predict=%0d dist=%0d expected all 0", am_rd_addr_o, predict_o, dist_o);
        end
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (qhv_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", qhv_ready_o);
        end
        // Reset in the middle of a 16-class search
        for (int k = 0; k < NC; k++) mem[k] = rand_hv();
        qhv_i = mem[0]; num_class_i = 5'd16; qhv_valid_i = 1'b1;
        step();
        qhv_valid_i = 1'b0;
        repeat (5) step();
        rst_i = 1'b1;
        en_seen = 0; pv_seen = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (am_rd_en_o) en_seen++;
            if (qhv_ready_o) en_seen++;
            if (predict_valid_o) pv_seen++;
            step();
        end
        rst_i = 1'b0;
        n_checks++;
        if (en_seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_en: rd_en/ready high %0d times expected 0", en_seen);
        end
        #1;
        n_checks++;
        if (qhv_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_ready: got %b expected 1", qhv_ready_o);
        end
        for (int c = 0; c < 25; c++) begin
            if (predict_valid_o || am_rd_en_o) pv_seen++;
            step();
        end
        n_checks++;
        if (pv_seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_novalid: valid/rd_en seen %0d times expected 0", pv_seen);
        end
    endtask

    task automatic test_exact_match();
        int lat, nr, ae;
        logic [AW-1:0] pi;
        logic [DW-1:0] pd;
        for (int k = 0; k < NC; k++) mem[k] = rand_hv();
        run_query(mem[5], 5'd16, lat, nr, ae, pi, pd);
        n_checks++;
        if (pi !== 4'd5 || pd !== 10'd0) begin
            n_fail++;
            $display("FAIL exact_result: got idx=%0d dist=%0d expected idx=5 dist=0", pi, pd);
        end
        n_checks++;
        if (lat !== 17) begin
            n_fail++;
            $display("FAIL exact_latency: got %0d edges expected 17", lat);
        end
        n_checks++;
        if (nr !== 16 || ae !== 0) begin
            n_fail++;
            $display("FAIL exact_reads: got %0d reads, %0d addr errors expected 16, 0", nr, ae);
        end
        step();
        n_checks++;
        if (predict_valid_o !== 1'b0 || qhv_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL exact_consume: valid=%b ready=%b expected 0 1", predict_valid_o, qhv_ready_o);
        end
    endtask

    task automatic test_tie();
        int lat, nr, ae;
        logic [AW-1:0] pi;
        logic [DW-1:0] pd;
        logic [D-1:0] q;
        q = rand_hv();
        for (int k = 0; k < NC; k++) mem[k] = q ^ mask_range(0, 300);
        mem[2] = q ^ mask_range(0, 10);
        mem[9] = q ^ mask_range(100, 10);
        run_query(q, 5'd16, lat, nr, ae, pi, pd);
        n_checks++;
        if (pi !== 4'd2 || pd !== 10'd10) begin
            n_fail++;
            $display("FAIL tie_result: got idx=%0d dist=%0d expected idx=2 dist=10", pi, pd);
        end
        step();
    endtask

    task automatic test_class_count();
        int lat, nr, ae;
        logic [AW-1:0] pi;
        logic [DW-1:0] pd;
        logic [D-1:0] q;
        q = rand_hv();
        for (int k = 0; k < NC; k++) mem[k] = q ^ mask_range(200, 300);
        mem[7] = q;
        mem[1] = q ^ mask_range(5, 30);
        run_query(q, 5'd4, lat, nr, ae, pi, pd);
        n_checks++;
        if (pi !== 4'd1 || pd !== 10'd30) begin
            n_fail++;
            $display("FAIL count4_result: got idx=%0d dist=%0d expected idx=1 dist=30", pi, pd);
        end
        n_checks++;
        if (lat !== 5 || nr !== 4 || ae !== 0) begin
            n_fail++;
            $display("FAIL count4_timing: got lat=%0d reads=%0d aerr=%0d expected 5 4 0", lat, nr, ae);
        end
        step();
        run_query(q, 5'd0, lat, nr, ae, pi, pd);
        n_checks++;
        if (pi !== 4'd7 || pd !== 10'd0 || nr !== 16 || lat !== 17) begin
            n_fail++;
            $display("FAIL count0: got idx=%0d dist=%0d reads=%0d lat=%0d expected 7 0 16 17", pi, pd, nr, lat);
        end
        step();
        run_query(q, 5'd20, lat, nr, ae, pi, pd);
        n_checks++;
        if (pi !== 4'd7 || pd !== 10'd0 || nr !== 16) begin
            n_fail++;
            $display("FAIL count20: got idx=%0d dist=%0d reads=%0d expected 7 0 16", pi, pd, nr);
        end
        step();
    endtask

    task automatic test_max_distance();
        int lat, nr, ae;
        logic [AW-1:0] pi;
        logic [DW-1:0] pd;
        logic [D-1:0] c;
        c = rand_hv();
        for (int k = 0; k < NC; k++) mem[k] = c;
        run_query(~c, 5'd1, lat, nr, ae, pi, pd);
        n_checks++;
        if (pi !== 4'd0 || pd !== 10'd512) begin
            n_fail++;
            $display("FAIL maxdist_result: got idx=%0d dist=%0d expected idx=0 dist=512", pi, pd);
        end
        n_checks++;
        if (lat !== 2 || nr !== 1) begin
            n_fail++;
            $display("FAIL maxdist_timing: got lat=%0d reads=%0d expected 2 1", lat, nr);
        end
        step();
    endtask

    task automatic test_backpressure();
        int lat, nr, ae, bad, w;
        logic [AW-1:0] pi;
        logic [DW-1:0] pd;
        for (int k = 0; k < NC; k++) mem[k] = rand_hv();
        predict_ready_i = 1'b0;
        run_query(mem[4], 5'd16, lat, nr, ae, pi, pd);
        n_checks++;
        if (pi !== 4'd4 || pd !== 10'd0) begin
            n_fail++;
            $display("FAIL bp_result: got idx=%0d dist=%0d expected idx=4 dist=0", pi, pd);
        end
        qhv_i = mem[3]; num_class_i = 5'd16; qhv_valid_i = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (predict_valid_o !== 1'b1 || predict_o !== 4'd4 || dist_o !== 10'd0) bad++;
            if (qhv_ready_o !== 1'b0 || am_rd_en_o !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable cycles expected 0", bad);
        end
        predict_ready_i = 1'b1;
        step();
        n_checks++;
        if (predict_valid_o !== 1'b0 || qhv_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b expected 0 1", predict_valid_o, qhv_ready_o);
        end
        step();
        qhv_valid_i = 1'b0;
        n_checks++;
        if (am_rd_en_o !== 1'b1 || am_rd_addr_o !== 4'd0 || qhv_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_accept: en=%b addr=%0d ready=%b expected 1 0 0", am_rd_en_o, am_rd_addr_o, qhv_ready_o);
        end
        qhv_i = mem[8];
        w = 0;
        while (!predict_valid_o && w < 200) begin
            step();
            w++;
        end
        n_checks++;
        if (predict_o !== 4'd3 || dist_o !== 10'd0 || w !== 17) begin
            n_fail++;
            $display("FAIL bp_second: got idx=%0d dist=%0d wait=%0d expected 3 0 17", predict_o, dist_o, w);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int first, second, vlen, vmax, badres, w;
        for (int k = 0; k < NC; k++) mem[k] = rand_hv();
        predict_ready_i = 1'b1;
        qhv_i = mem[1]; num_class_i = 5'd2; qhv_valid_i = 1'b1;
        first = -1; second = -1; vlen = 0; vmax = 0; badres = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (am_rd_en_o && am_rd_addr_o == 4'd0) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (predict_valid_o) begin
                vlen++;
                if (predict_o !== 4'd1 || dist_o !== 10'd0) badres++;
            end else begin
                vlen = 0;
            end
            if (vlen > vmax) vmax = vlen;
        end
        qhv_valid_i = 1'b0;
        n_checks++;
        if (second - first !== 5) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d cycles expected 5", second - first);
        end
        n_checks++;
        if (vmax !== 1 || badres !== 0) begin
            n_fail++;
            $display("FAIL b2b_valid: max valid run %0d, bad results %0d expected 1, 0", vmax, badres);
        end
        w = 0;
        while (!qhv_ready_o && w < 50) begin
            step();
            w++;
        end
        n_checks++;
        if (qhv_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_idle: ready=%b expected 1", qhv_ready_o);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        qhv_i = '0;
        qhv_valid_i = 1'b0;
        num_class_i = '0;
        predict_ready_i = 1'b1;
        am_rd_data_i = '0;
        for (int k = 0; k < NC; k++) mem[k] = '0;
        test_reset();
        test_exact_match();
        test_tie();
        test_class_count();
        test_max_distance();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
